// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// ALU function codes, operation encodings, FSM states and a magnitude helper.
package muldiv_seq_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_LT  = 6'b110101;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Magnitude of a 32-bit value when signed interpretation is enabled.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequencer for MULT/MULTU/DIV/DIVU that borrows the shared 32-bit ALU.
// Multiplies by shift-add and divides by restoring division over ITER
// iterations, working on magnitudes and fixing signs at the end.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_out
);

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t      state_r, state_s;
    op_t         op_r;
    logic [31:0] rs_r, rt_r;
    logic [31:0] mag_r;            // |rs| for multiply, |rt| for divide
    logic [31:0] hi_acc_r, lo_acc_r;
    logic        neg_hi_r, neg_lo_r, dz_pend_r;
    logic [4:0]  cnt_r;
    logic        busy_r, done_r, dz_r;
    logic [31:0] hi_r, lo_r;

    logic        accept_s, is_mul_s, is_signed_s;
    logic [31:0] div_t_s;
    logic        carry_s, borrow_s, take_sub_s;
    logic [31:0] step_hi_s, step_lo_s;
    logic [63:0] prod_neg_s;

    assign accept_s    = (state_r == ST_IDLE) && start && !busy_r;
    assign is_mul_s    = ~op_r[1];
    assign is_signed_s = op_r[0];
    assign div_t_s     = {hi_acc_r[30:0], lo_acc_r[31]};
    assign prod_neg_s  = 64'd0 - {hi_acc_r, lo_acc_r};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_PREP;
                else          state_s = ST_IDLE;
            end
            ST_PREP: begin
                if (op_r[1] && (rt_r == 32'd0)) state_s = ST_DONE;
                else                            state_s = ST_ITER;
            end
            ST_ITER: begin
                if (cnt_r == LAST_CNT) state_s = ST_FIX;
                else                   state_s = ST_ITER;
            end
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // ALU operand drive: only active while iterating, idle as ADD 0+0.
    always_comb begin
        alu_in1 = 32'd0;
        alu_in2 = 32'd0;
        alu_fun = ALU_ADD;
        if (state_r == ST_ITER) begin
            if (is_mul_s) begin
                alu_in1 = hi_acc_r;
                alu_in2 = lo_acc_r[0] ? mag_r : 32'd0;
                alu_fun = ALU_ADD;
            end else begin
                alu_in1 = div_t_s;
                alu_in2 = mag_r;
                alu_fun = ALU_SUB;
            end
        end else begin
            alu_in1 = 32'd0;
            alu_in2 = 32'd0;
            alu_fun = ALU_ADD;
        end
    end

    assign alu_sign = 1'b0;

    // One iteration step: carry/borrow rebuilt from operand and result MSBs.
    always_comb begin
        carry_s    = (alu_in1[31] & alu_in2[31]) | ((alu_in1[31] | alu_in2[31]) & ~alu_out[31]);
        borrow_s   = (~alu_in1[31] & alu_in2[31]) | ((~alu_in1[31] | alu_in2[31]) & alu_out[31]);
        take_sub_s = hi_acc_r[31] | ~borrow_s;
        step_hi_s  = hi_acc_r;
        step_lo_s  = lo_acc_r;
        if (is_mul_s) begin
            step_hi_s = {carry_s, alu_out[31:1]};
            step_lo_s = {alu_out[0], lo_acc_r[31:1]};
        end else begin
            step_hi_s = take_sub_s ? alu_out : div_t_s;
            step_lo_s = {lo_acc_r[30:0], take_sub_s};
        end
    end

    // Operand capture, magnitude/sign preparation, iteration and sign fix.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= OP_MULTU;
            rs_r      <= 32'd0;
            rt_r      <= 32'd0;
            mag_r     <= 32'd0;
            hi_acc_r  <= 32'd0;
            lo_acc_r  <= 32'd0;
            neg_hi_r  <= 1'b0;
            neg_lo_r  <= 1'b0;
            dz_pend_r <= 1'b0;
            cnt_r     <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r <= op_t'(op);
                        rs_r <= rs;
                        rt_r <= rt;
                    end
                end
                ST_PREP: begin
                    cnt_r    <= 5'd0;
                    hi_acc_r <= 32'd0;
                    if (op_r[1] && (rt_r == 32'd0)) begin
                        hi_acc_r  <= rs_r;
                        lo_acc_r  <= 32'hFFFF_FFFF;
                        neg_hi_r  <= 1'b0;
                        neg_lo_r  <= 1'b0;
                        dz_pend_r <= 1'b1;
                    end else if (is_mul_s) begin
                        lo_acc_r  <= mag32(rt_r, is_signed_s);
                        mag_r     <= mag32(rs_r, is_signed_s);
                        neg_hi_r  <= is_signed_s & (rs_r[31] ^ rt_r[31]);
                        neg_lo_r  <= is_signed_s & (rs_r[31] ^ rt_r[31]);
                        dz_pend_r <= 1'b0;
                    end else begin
                        lo_acc_r  <= mag32(rs_r, is_signed_s);
                        mag_r     <= mag32(rt_r, is_signed_s);
                        neg_hi_r  <= is_signed_s & rs_r[31];
                        neg_lo_r  <= is_signed_s & (rs_r[31] ^ rt_r[31]);
                        dz_pend_r <= 1'b0;
                    end
                end
                ST_ITER: begin
                    hi_acc_r <= step_hi_s;
                    lo_acc_r <= step_lo_s;
                    cnt_r    <= cnt_r + 5'd1;
                end
                ST_FIX: begin
                    if (is_mul_s) begin
                        if (neg_lo_r) {hi_acc_r, lo_acc_r} <= prod_neg_s;
                    end else begin
                        if (neg_hi_r) hi_acc_r <= 32'd0 - hi_acc_r;
                        if (neg_lo_r) lo_acc_r <= 32'd0 - lo_acc_r;
                    end
                end
                ST_DONE: begin
                    cnt_r <= 5'd0;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Registered handshake and result outputs; busy drops after the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                busy_r <= 1'b1;
                dz_r   <= 1'b0;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end
            if (state_r == ST_DONE) begin
                hi_r   <= hi_acc_r;
                lo_r   <= lo_acc_r;
                dz_r   <= dz_pend_r;
                done_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dz   = dz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized
// operations against an arithmetic reference model, and multi-cycle
// corner sequences (start while busy, reset mid-operation).
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done, dz, alu_sign;
    logic [31:0] hi, lo, alu_in1, alu_in2, alu_out;
    logic [5:0]  alu_fun;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_seq #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_fun(alu_fun),
        .alu_sign(alu_sign), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // External ALU: ADD and SUB are the only functions the sequencer uses.
    always_comb begin
        if (alu_fun == 6'b000001) alu_out = alu_in1 - alu_in2;
        else                      alu_out = alu_in1 + alu_in2;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operation.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
        logic [63:0] p, qv, rv;
        longint sa, sb;
        mdz = 1'b0;
        if (o[1] && b == 32'd0) begin
            mhi = a; mlo = 32'hFFFF_FFFF; mdz = 1'b1;
        end else if (o == 2'b00) begin
            p = {32'd0, a} * {32'd0, b};
            mhi = p[63:32]; mlo = p[31:0];
        end else if (o == 2'b01) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            p = sa * sb;
            mhi = p[63:32]; mlo = p[31:0];
        end else if (o == 2'b10) begin
            mlo = a / b; mhi = a % b;
        end else begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            qv = sa / sb; rv = sa % sb;
            mlo = qv[31:0]; mhi = rv[31:0];
        end
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Issue one op, track busy each cycle, return result sampled in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at, output int lat,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        logic busy_bad;
        busy_bad = 1'b0;
        lat = -1;
        start_op(o, a, b);
        chk("dz_clear_on_start", {63'd0, dz}, 64'd0);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (k == glitch_at) begin
                start = 1'b1; op = 2'b00; rs = 32'd9; rt = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        rhi = hi; rlo = lo; rdz = dz;
        chk("busy_while_running", {63'd0, busy_bad}, 64'd0);
        chk("busy_in_done_cycle", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        chk("done_single_pulse", {63'd0, done}, 64'd0);
        chk("busy_cleared", {63'd0, busy}, 64'd0);
        chk("hi_held", {32'd0, hi}, {32'd0, rhi});
        chk("alu_idle_in1", {32'd0, alu_in1}, 64'd0);
        chk("alu_idle_fun", {58'd0, alu_fun}, 64'd0);
    endtask

    vec_t        tbl [7];
    int          lat;
    logic [31:0] rhi, rlo, ehi, elo;
    logic        rdz, edz, saw_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs = 32'd0; rt = 32'd0;
        tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35};
        tbl[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35};
        tbl[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
        tbl[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 35};
        tbl[4] = '{2'b10, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2};
        tbl[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35};
        tbl[6] = '{2'b11, 32'h0000_0007, 32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, dz}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_alu_in1", {32'd0, alu_in1}, 64'd0);
        chk("rst_alu_in2", {32'd0, alu_in2}, 64'd0);
        chk("rst_alu_fun", {58'd0, alu_fun}, 64'd0);
        chk("rst_alu_sign", {63'd0, alu_sign}, 64'd0);
        reset = 1'b0;

        // Directed table; DIV overflow case gets a start pulse while busy.
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, (i == 5) ? 5 : 0, lat, rhi, rlo, rdz);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_hi", i), {32'd0, rhi}, {32'd0, tbl[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, rlo}, {32'd0, tbl[i].lo});
            chk($sformatf("vec%0d_dz", i), {63'd0, rdz}, {63'd0, tbl[i].dz});
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 20));
                1:       rb = 32'd0 - 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i % 7 == 3) ra = 32'h8000_0000;
            model(rop, ra, rb, ehi, elo, edz);
            run_op(rop, ra, rb, 0, lat, rhi, rlo, rdz);
            chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, rop, ra, rb), {32'd0, rhi}, {32'd0, ehi});
            chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, rop, ra, rb), {32'd0, rlo}, {32'd0, elo});
            chk($sformatf("rnd%0d_dz", i), {63'd0, rdz}, {63'd0, edz});
            chk($sformatf("rnd%0d_latency", i), 64'(lat), edz ? 64'd2 : 64'd35);
        end

        // Leave a nonzero result, then reset in the middle of an operation.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, rhi, rlo, rdz);
        start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_alu_fun", {58'd0, alu_fun}, 64'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
        chk("midrst_lo_held", {32'd0, lo}, 64'd0);
        run_op(2'b00, 32'd3, 32'd5, 0, lat, rhi, rlo, rdz);
        chk("post_rst_lo", {32'd0, rlo}, 64'd15);
        chk("post_rst_hi", {32'd0, rhi}, 64'd0);
        chk("post_rst_latency", 64'(lat), 64'd35);

        // Reset asserted together with start wins.
        @(negedge clk);
        start = 1'b1; reset = 1'b1; op = 2'b00; rs = 32'd2; rt = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; reset = 1'b0;
        chk("start_with_reset_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("start_with_reset_lo", {32'd0, lo}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
